config_frame_loader: RTL and testbench

Serial configuration loader that sits directly upstream of each `switch_box` tile. It accepts an addressed bitstream frame from the configuration chain and, when the frame targets this tile, presents the 32-bit word on `config_data` with a one-cycle `config_en` strobe. It also forwards the raw stream, registered, to the next tile in the daisy chain.

---
 rtl/config_loader_pkg.sv | 39 +++
 rtl/config_shift_reg.sv | 40 ++++
 rtl/config_frame_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_config_frame_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_loader_pkg
// Description : Shared widths, FSM state encoding and helper functions for
//               the serial configuration frame loader.
// Revision    : 1.0 - initial release
// ============================================================================
package config_loader_pkg;

    // Default frame field widths
    localparam int c_DEFAULT_WORD_W = 32;
    localparam int c_DEFAULT_ID_W   = 8;

    // Loader FSM state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_PAR  = 2'd3;

    // Larger of two integers, used to size the shared bit counter
    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // True when the low 'width' bits of addr are all ones (broadcast address)
    function automatic logic f_is_broadcast(input logic [31:0] addr, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i < width) && !addr[i]) begin
                all_ones = 1'b0;
            end
        end
        return all_ones;
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : config_shift_reg
// Description : MSB-first serial-in shift register with shift enable and
//               clear. Clear together with enable loads the incoming bit into
//               an otherwise zeroed register (start of a new field).
// Revision    : 1.0 - initial release
// ============================================================================
module config_shift_reg
    import config_loader_pkg::*;
#(
    parameter int W = c_DEFAULT_ID_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Shift new bits in at the LSB so the first bit received ends up as MSB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_clr && i_en) begin
            r_q <= W'(i_bit);
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= (r_q << 1) | W'(i_bit);
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/config_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_loader
// Description : Serial configuration loader for one switch_box tile. Decodes
//               an addressed frame (address, data word, optional parity) from
//               the configuration chain, strobes the word to the tile when the
//               address matches TILE_ID or broadcast, and forwards the raw
//               stream one cycle later to the next tile.
// Options     : CONFIG_LOADER_PARITY_EN - append an even-parity bit to every
//               frame and reject frames whose parity is wrong.
// Revision    : 1.0 - initial release
// ============================================================================
module config_frame_loader
    import config_loader_pkg::*;
#(
    parameter int              WORD_W  = c_DEFAULT_WORD_W,
    parameter int              ID_W    = c_DEFAULT_ID_W,
    parameter logic [ID_W-1:0] TILE_ID = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              frame_start,
    output logic              config_en,
    output logic [WORD_W-1:0] config_data,
    output logic              busy,
    output logic              frame_err,
    output logic              bit_valid_out,
    output logic              bit_out,
    output logic              frame_start_out
);

    localparam int              CNT_W       = $clog2(f_max(ID_W, WORD_W) + 1);
    localparam logic [CNT_W-1:0] c_ADDR_LAST = CNT_W'(ID_W - 1);
    localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(WORD_W - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_match;
    logic              r_config_en;
    logic [WORD_W-1:0] r_config_data;
    logic              r_frame_err;
    logic              r_fwd_valid;
    logic              r_fwd_bit;
    logic              r_fwd_start;

    logic [ID_W-1:0]   w_addr_q;
    logic [WORD_W-1:0] w_data_q;
    logic [ID_W-1:0]   w_addr_next;
    logic              w_match_val;
    logic              w_start;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_addr_clr;
    logic              w_addr_en;
    logic              w_data_clr;
    logic              w_data_en;
    logic              w_match_ld;
    logic              w_commit;
    logic [WORD_W-1:0] w_commit_word;
    logic              w_err;

    // A start bit is only meaningful when it is also a valid stream bit
    assign w_start     = bit_valid & frame_start;
    // Address value including the bit arriving this cycle
    assign w_addr_next = (w_addr_q << 1) | ID_W'(bit_in);
    assign w_match_val = (w_addr_next == TILE_ID) || f_is_broadcast(32'(w_addr_next), ID_W);

`ifdef CONFIG_LOADER_PARITY_EN
    logic r_par;
    logic w_par_ok;

    // Even parity: running XOR of every bit of the frame so far plus this one
    assign w_par_ok = ~(r_par ^ bit_in);

    // Accumulate parity over the address and data bits of the current frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_start) begin
            r_par <= bit_in;
        end else if (bit_valid && (r_state != c_IDLE)) begin
            r_par <= r_par ^ bit_in;
        end
    end
`else
    logic [WORD_W-1:0] w_data_next;

    // Without parity the last data bit commits directly, so include it here
    assign w_data_next = (w_data_q << 1) | WORD_W'(bit_in);
`endif

    config_shift_reg #(
        .W (ID_W)
    ) u_addr_sr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_addr_clr),
        .i_en  (w_addr_en),
        .i_bit (bit_in),
        .o_q   (w_addr_q)
    );

    config_shift_reg #(
        .W (WORD_W)
    ) u_data_sr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_data_clr),
        .i_en  (w_data_en),
        .i_bit (bit_in),
        .o_q   (w_data_q)
    );

    // Frame sequencing: a start bit always (re)opens a frame, aborting any
    // frame in progress; other valid bits advance the current field
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_clr    = 1'b0;
        w_addr_en     = 1'b0;
        w_data_clr    = 1'b0;
        w_data_en     = 1'b0;
        w_match_ld    = 1'b0;
        w_commit      = 1'b0;
        w_commit_word = w_data_q;
        w_err         = 1'b0;

        if (w_start) begin
            w_err       = (r_state != c_IDLE);
            w_state_nxt = c_ADDR;
            w_cnt_nxt   = CNT_W'(1);
            w_addr_clr  = 1'b1;
            w_addr_en   = 1'b1;
            w_data_clr  = 1'b1;
        end else if (bit_valid) begin
            case (r_state)
                c_ADDR: begin
                    w_addr_en = 1'b1;
                    if (r_cnt == c_ADDR_LAST) begin
                        w_state_nxt = c_DATA;
                        w_cnt_nxt   = '0;
                        w_match_ld  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                c_DATA: begin
                    w_data_en = 1'b1;
                    if (r_cnt == c_DATA_LAST) begin
`ifdef CONFIG_LOADER_PARITY_EN
                        w_state_nxt = c_PAR;
                        w_cnt_nxt   = '0;
`else
                        w_state_nxt   = c_IDLE;
                        w_cnt_nxt     = '0;
                        w_commit      = r_match;
                        w_commit_word = w_data_next;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
`ifdef CONFIG_LOADER_PARITY_EN
                c_PAR: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                    w_commit    = r_match & w_par_ok;
                    w_err       = ~w_par_ok;
                end
`endif
                default: begin
                    // IDLE: non-start bits belong to no frame and are ignored
                end
            endcase
        end
    end

    // FSM state, bit counter and latched address-match flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_match_ld) begin
                r_match <= w_match_val;
            end
        end
    end

    // Commit strobe, held configuration word and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_config_en   <= 1'b0;
            r_config_data <= '0;
            r_frame_err   <= 1'b0;
        end else begin
            r_config_en <= w_commit;
            r_frame_err <= w_err;
            if (w_commit) begin
                r_config_data <= w_commit_word;
            end
        end
    end

    // Daisy-chain forwarding: raw inputs delayed by exactly one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_bit   <= 1'b0;
            r_fwd_start <= 1'b0;
        end else begin
            r_fwd_valid <= bit_valid;
            r_fwd_bit   <= bit_in;
            r_fwd_start <= frame_start;
        end
    end

    assign config_en       = r_config_en;
    assign config_data     = r_config_data;
    assign frame_err       = r_frame_err;
    assign busy            = (r_state != c_IDLE);
    assign bit_valid_out   = r_fwd_valid;
    assign bit_out         = r_fwd_bit;
    assign frame_start_out = r_fwd_start;

endmodule
`default_nettype wire

// File: tb/tb_config_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_frame_loader
// Description : Self-checking bench for config_frame_loader (TILE_ID=8'h05).
//               A queue-based frame model predicts commits, errors, busy and
//               forwarding; each scenario task checks its own results.
// Options     : CONFIG_LOADER_PARITY_EN - frames carry a parity bit and the
//               parity scenario is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_frame_loader;

    localparam int         WORD_W = 32;
    localparam int         ID_W   = 8;
    localparam logic [7:0] TILE   = 8'h05;
`ifdef CONFIG_LOADER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FLEN = ID_W + WORD_W + PB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        frame_start = 1'b0;
    logic        config_en;
    logic [31:0] config_data;
    logic        busy;
    logic        frame_err;
    logic        bit_valid_out;
    logic        bit_out;
    logic        frame_start_out;

    always #5 clk = ~clk;

    config_frame_loader #(
        .WORD_W  (WORD_W),
        .ID_W    (ID_W),
        .TILE_ID (TILE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bit_valid       (bit_valid),
        .bit_in          (bit_in),
        .frame_start     (frame_start),
        .config_en       (config_en),
        .config_data     (config_data),
        .busy            (busy),
        .frame_err       (frame_err),
        .bit_valid_out   (bit_valid_out),
        .bit_out         (bit_out),
        .frame_start_out (frame_start_out)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: bits of the open frame, held word, per-cycle expectations
    bit          m_q[$];
    bit          m_in;
    logic [31:0] m_cfg;
    logic        m_en;
    logic        m_err;

    // Per-scenario tallies
    int t_cyc, d_en_cnt, d_en_cyc, d_err_cnt, d_err_cyc, m_en_cnt, m_en_cyc, m_err_cnt;
    int en_diff, err_diff, busy_diff, fwd_diff, data_diff;

    task automatic tally_clear();
        t_cyc = 0; d_en_cnt = 0; d_en_cyc = -1; d_err_cnt = 0; d_err_cyc = -1;
        m_en_cnt = 0; m_en_cyc = -1; m_err_cnt = 0;
        en_diff = 0; err_diff = 0; busy_diff = 0; fwd_diff = 0; data_diff = 0;
    endtask

    task automatic model_reset();
        m_q.delete(); m_in = 0; m_cfg = '0;
    endtask

    // Drive one cycle, advance the model, and record DUT behaviour after the edge
    task automatic step(input logic v, input logic s, input logic b);
        logic [ID_W-1:0]   a;
        logic [WORD_W-1:0] d;
        logic [2:0]        fwd_exp;
        bit                px;
        bit                match;
        bit                pok;
        bit_valid = v; frame_start = s; bit_in = b;
        m_en = 1'b0; m_err = 1'b0;
        if (v) begin
            if (s) begin
                if (m_in) m_err = 1'b1;
                m_q.delete(); m_q.push_back(b); m_in = 1;
            end else if (m_in) begin
                m_q.push_back(b);
            end
            if (m_in && (m_q.size() == FLEN)) begin
                a = '0; d = '0; px = 0;
                for (int i = 0; i < ID_W; i++) a = {a[ID_W-2:0], m_q[i]};
                for (int i = 0; i < WORD_W; i++) d = {d[WORD_W-2:0], m_q[ID_W+i]};
                foreach (m_q[i]) px ^= m_q[i];
                match = (a == TILE) || (a == 8'hFF);
                pok   = (PB == 0) || (px == 0);
                if (match && pok) begin m_en = 1'b1; m_cfg = d; end
                if (!pok) m_err = 1'b1;
                m_in = 0;
            end
        end
        fwd_exp = {v, b, s};
        @(posedge clk);
        #1;
        t_cyc++;
        if (m_en) begin m_en_cnt++; m_en_cyc = t_cyc; end
        if (m_err) m_err_cnt++;
        if (config_en === 1'b1) begin d_en_cnt++; d_en_cyc = t_cyc; end
        if (frame_err === 1'b1) begin d_err_cnt++; d_err_cyc = t_cyc; end
        if (config_en !== m_en) en_diff++;
        if (frame_err !== m_err) err_diff++;
        if (busy !== m_in) busy_diff++;
        if ({bit_valid_out, bit_out, frame_start_out} !== fwd_exp) fwd_diff++;
        if (config_data !== m_cfg) data_diff++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom));
    endtask

    // Send the first nbits bits of a frame, with random idle gaps of gap percent
    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input int gap,
                              input bit flip, input int nbits);
        logic [ID_W+WORD_W:0] fr;
        fr = {a, d, (^{a, d}) ^ flip};
        for (int i = 0; i < nbits; i++) begin
            while ($urandom_range(99) < gap) step(1'b0, 1'b0, 1'($urandom));
            step(1'b1, (i == 0), fr[ID_W+WORD_W-i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (config_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", config_en); end
        n_total++; if (config_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", config_data); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_total++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        n_total++; if ({bit_valid_out, bit_out, frame_start_out} !== 3'b000) begin
            n_bad++; $display("FAIL reset_fwd: got %b want 000", {bit_valid_out, bit_out, frame_start_out}); end
        rst = 1'b1;
    endtask

    task automatic test_good_frame();
        tally_clear();
        send_frame(8'h05, 32'hDEADBEEF, 0, 0, FLEN);
        idle(3);
        n_total++; if (d_en_cnt !== 1) begin n_bad++; $display("FAIL good_en_count: got %0d want 1", d_en_cnt); end
        n_total++; if (d_en_cyc !== FLEN) begin n_bad++; $display("FAIL good_en_cycle: got %0d want %0d", d_en_cyc, FLEN); end
        n_total++; if (config_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL good_data: got %h want deadbeef", config_data); end
        n_total++; if (d_err_cnt !== 0) begin n_bad++; $display("FAIL good_err: got %0d want 0", d_err_cnt); end
        n_total++; if (busy_diff !== 0) begin n_bad++; $display("FAIL good_busy: %0d cycles differ, want 0", busy_diff); end
        n_total++; if (data_diff !== 0) begin n_bad++; $display("FAIL good_data_hold: %0d cycles differ, want 0", data_diff); end
        n_total++; if (fwd_diff !== 0) begin n_bad++; $display("FAIL good_fwd: %0d cycles differ, want 0", fwd_diff); end
    endtask

    task automatic test_no_match();
        tally_clear();
        send_frame(8'h06, 32'h12345678, 0, 0, FLEN);
        idle(3);
        n_total++; if (d_en_cnt !== 0) begin n_bad++; $display("FAIL nomatch_en: got %0d want 0", d_en_cnt); end
        n_total++; if (d_err_cnt !== 0) begin n_bad++; $display("FAIL nomatch_err: got %0d want 0", d_err_cnt); end
        n_total++; if (config_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL nomatch_data: got %h want deadbeef", config_data); end
        n_total++; if (busy_diff !== 0) begin n_bad++; $display("FAIL nomatch_busy: %0d cycles differ, want 0", busy_diff); end
        tally_clear();
        send_frame(8'hFF, 32'h12345678, 0, 0, FLEN);
        idle(2);
        n_total++; if (d_en_cnt !== 1) begin n_bad++; $display("FAIL bcast_en: got %0d want 1", d_en_cnt); end
        n_total++; if (d_en_cyc !== FLEN) begin n_bad++; $display("FAIL bcast_cycle: got %0d want %0d", d_en_cyc, FLEN); end
        n_total++; if (config_data !== 32'h12345678) begin n_bad++; $display("FAIL bcast_data: got %h want 12345678", config_data); end
    endtask

    task automatic test_gaps();
        tally_clear();
        send_frame(8'h05, 32'hDEADBEEF, 50, 0, FLEN);
        idle(3);
        n_total++; if (d_en_cnt !== 1) begin n_bad++; $display("FAIL gaps_en_count: got %0d want 1", d_en_cnt); end
        n_total++; if (d_en_cyc !== m_en_cyc) begin n_bad++; $display("FAIL gaps_en_cycle: got %0d want %0d", d_en_cyc, m_en_cyc); end
        n_total++; if (config_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL gaps_data: got %h want deadbeef", config_data); end
        n_total++; if (busy_diff !== 0) begin n_bad++; $display("FAIL gaps_busy: %0d cycles differ, want 0", busy_diff); end
    endtask

    task automatic test_abort();
        tally_clear();
        send_frame(8'h05, 32'h0F0F0F0F, 0, 0, 20);
        send_frame(8'h05, 32'hA5A5A5A5, 0, 0, FLEN);
        idle(3);
        n_total++; if (d_err_cnt !== 1) begin n_bad++; $display("FAIL abort_err_count: got %0d want 1", d_err_cnt); end
        n_total++; if (d_err_cyc !== 21) begin n_bad++; $display("FAIL abort_err_cycle: got %0d want 21", d_err_cyc); end
        n_total++; if (d_en_cnt !== 1) begin n_bad++; $display("FAIL abort_en_count: got %0d want 1", d_en_cnt); end
        n_total++; if (d_en_cyc !== 20 + FLEN) begin n_bad++; $display("FAIL abort_en_cycle: got %0d want %0d", d_en_cyc, 20 + FLEN); end
        n_total++; if (config_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL abort_data: got %h want a5a5a5a5", config_data); end
        n_total++; if (busy_diff !== 0) begin n_bad++; $display("FAIL abort_busy: %0d cycles differ, want 0", busy_diff); end
    endtask

`ifdef CONFIG_LOADER_PARITY_EN
    task automatic test_parity();
        tally_clear();
        send_frame(8'h05, 32'h01234567, 0, 0, FLEN);
        idle(2);
        n_total++; if (d_en_cyc !== 41) begin n_bad++; $display("FAIL par_good_cycle: got %0d want 41", d_en_cyc); end
        n_total++; if (config_data !== 32'h01234567) begin n_bad++; $display("FAIL par_good_data: got %h want 01234567", config_data); end
        tally_clear();
        send_frame(8'h05, 32'h89ABCDEF, 0, 1, FLEN);
        idle(2);
        n_total++; if (d_en_cnt !== 0) begin n_bad++; $display("FAIL par_bad_en: got %0d want 0", d_en_cnt); end
        n_total++; if (d_err_cyc !== 41) begin n_bad++; $display("FAIL par_bad_err_cycle: got %0d want 41", d_err_cyc); end
        n_total++; if (config_data !== 32'h01234567) begin n_bad++; $display("FAIL par_bad_data: got %h want 01234567", config_data); end
        tally_clear();
        send_frame(8'h3C, 32'h89ABCDEF, 0, 1, FLEN);
        idle(2);
        n_total++; if (d_err_cnt !== 1) begin n_bad++; $display("FAIL par_nomatch_err: got %0d want 1", d_err_cnt); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] a;
        tally_clear();
        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(2))
                0:       a = 8'h05;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            send_frame(a, $urandom, (f % 3 == 2) ? 25 : 0, (PB != 0) && ($urandom_range(3) == 0), FLEN);
        end
        idle(3);
        n_total++; if (d_en_cnt !== m_en_cnt) begin n_bad++; $display("FAIL b2b_en_count: got %0d want %0d", d_en_cnt, m_en_cnt); end
        n_total++; if (d_err_cnt !== m_err_cnt) begin n_bad++; $display("FAIL b2b_err_count: got %0d want %0d", d_err_cnt, m_err_cnt); end
        n_total++; if (en_diff !== 0) begin n_bad++; $display("FAIL b2b_en_timing: %0d cycles differ, want 0", en_diff); end
        n_total++; if (data_diff !== 0) begin n_bad++; $display("FAIL b2b_data: %0d cycles differ, want 0", data_diff); end
        n_total++; if (busy_diff !== 0) begin n_bad++; $display("FAIL b2b_busy: %0d cycles differ, want 0", busy_diff); end
    endtask

    task automatic test_random_stream();
        tally_clear();
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom), ($urandom_range(59) == 0), 1'($urandom));
        end
        idle(3);
        n_total++; if (en_diff !== 0) begin n_bad++; $display("FAIL rand_en: %0d cycles differ, want 0", en_diff); end
        n_total++; if (err_diff !== 0) begin n_bad++; $display("FAIL rand_err: %0d cycles differ, want 0", err_diff); end
        n_total++; if (busy_diff !== 0) begin n_bad++; $display("FAIL rand_busy: %0d cycles differ, want 0", busy_diff); end
        n_total++; if (data_diff !== 0) begin n_bad++; $display("FAIL rand_data: %0d cycles differ, want 0", data_diff); end
        n_total++; if (fwd_diff !== 0) begin n_bad++; $display("FAIL rand_fwd: %0d cycles differ, want 0", fwd_diff); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        tally_clear();
        send_frame(8'h05, 32'hCAFEF00D, 0, 0, 30);
        rst = 1'b0;
        #2;
        n_total++; if (config_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_data: got %h want 0", config_data); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_total++; if ({config_en, frame_err} !== 2'b00) begin n_bad++; $display("FAIL rstmid_pulses: got %b want 00", {config_en, frame_err}); end
        n_total++; if ({bit_valid_out, bit_out, frame_start_out} !== 3'b000) begin
            n_bad++; $display("FAIL rstmid_fwd: got %b want 000", {bit_valid_out, bit_out, frame_start_out}); end
        bit_valid = 1'b0; frame_start = 1'b0; bit_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tally_clear();
        d = $urandom;
        send_frame(8'h05, d, 0, 0, FLEN);
        idle(3);
        n_total++; if (d_en_cnt !== 1) begin n_bad++; $display("FAIL rstmid_en_count: got %0d want 1", d_en_cnt); end
        n_total++; if (d_en_cyc !== FLEN) begin n_bad++; $display("FAIL rstmid_en_cycle: got %0d want %0d", d_en_cyc, FLEN); end
        n_total++; if (config_data !== d) begin n_bad++; $display("FAIL rstmid_new_data: got %h want %h", config_data, d); end
        n_total++; if (fwd_diff !== 0) begin n_bad++; $display("FAIL rstmid_fwd_track: %0d cycles differ, want 0", fwd_diff); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_no_match();
        test_gaps();
        test_abort();
`ifdef CONFIG_LOADER_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_random_stream();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
